// File: rtl/sd_cmd_pkg.sv
// -----------------------------------------------------------------------------
// sd_cmd_pkg
// Shared types and constants for the card-side SD CMD line endpoint:
//   state_e     - endpoint FSM states
//   *Bits       - token / response frame lengths in bits
//   CrcOnes     - CRC field value sent in R3 responses
//   crc7_step() - one serial step of CRC7 (x^7 + x^3 + 1)
// -----------------------------------------------------------------------------
package sd_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_WAIT_RESP,
        ST_NCR,
        ST_TX
    } state_e;

    localparam int          CmdTokenBits  = 48;
    localparam int          ShortRespBits = 48;
    localparam int          LongRespBits  = 136;
    localparam logic [6:0]  CrcOnes       = 7'h7F;

    // Serial CRC7, MSB-first: feedback taps at x^3 and x^0.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// -----------------------------------------------------------------------------
// sd_crc7
// Serial CRC7 accumulator shared by the receive and transmit paths.
// Ports:
//   clk_i    - clock
//   rst_ni   - asynchronous active-low reset
//   clear_i  - restart from zero; combines with en_i so the first bit is
//              folded in on the same edge
//   en_i     - accumulate bit_i this edge
//   bit_i    - serial data bit
//   crc_o    - current CRC register, crc_o[6] is the next bit to transmit
// Feeding crc_o[6] back in as bit_i shifts the register out with zeros, which
// the transmitter uses to serialise the CRC field.
// -----------------------------------------------------------------------------
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;
    logic [6:0] crc_base;

    always_comb begin
        crc_base = clear_i ? 7'd0 : crc_q;
        crc_d    = en_i ? crc7_step(crc_base, bit_i) : crc_base;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= 7'd0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_resp.sv
// -----------------------------------------------------------------------------
// sd_cmd_resp
// Card-side endpoint of the SD CMD line. Receives 48-bit host command tokens,
// checks transmission bit, CRC7 and end bit, presents index/argument, then
// sends a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response after the Ncr gap.
// Ports:
//   sdclk_i             - SD clock, all activity on the rising edge
//   rst_cmd_ni          - asynchronous active-low reset (releases the line)
//   cmd_i               - CMD line input, already synchronous to sdclk_i
//   cmd_o / cmd_t       - CMD drive value / tristate (1 = released)
//   cmd_valid_o         - one-cycle pulse per received token
//   cmd_index_o         - received command index (held)
//   cmd_argument_o      - received argument (held)
//   cmd_crc_error_o     - qualifies cmd_valid_o: CRC7 mismatch
//   cmd_end_bit_error_o - qualifies cmd_valid_o: end bit was 0
//   resp_valid_i        - response offered by card logic
//   resp_ready_o        - high while waiting for the response
//   resp_none_i         - command takes no response
//   resp_long_i         - 1 = 136-bit R2, 0 = 48-bit response
//   resp_crc_ones_i     - 48-bit only: send 7'h7F instead of computed CRC7
//   resp_payload_i      - short: [37:0]; long: [126:0]
// Parameter:
//   NcrCycles           - idle cycles between command end bit and response
//                         start bit (2..64)
// -----------------------------------------------------------------------------
module sd_cmd_resp
    import sd_cmd_pkg::*;
#(
    parameter int NcrCycles = 2
) (
    input  logic         sdclk_i,
    input  logic         rst_cmd_ni,
    input  logic         cmd_i,
    output logic         cmd_o,
    output logic         cmd_t,
    output logic         cmd_valid_o,
    output logic [5:0]   cmd_index_o,
    output logic [31:0]  cmd_argument_o,
    output logic         cmd_crc_error_o,
    output logic         cmd_end_bit_error_o,
    input  logic         resp_valid_i,
    output logic         resp_ready_o,
    input  logic         resp_none_i,
    input  logic         resp_long_i,
    input  logic         resp_crc_ones_i,
    input  logic [126:0] resp_payload_i
);

    localparam logic [6:0] NcrMax      = 7'(NcrCycles);
    localparam logic [7:0] RxLastBit   = 8'(CmdTokenBits - 1);
    localparam logic [7:0] ShortLast   = 8'(ShortRespBits - 1);
    localparam logic [7:0] LongLast    = 8'(LongRespBits - 1);
    localparam logic [7:0] CrcFirstBit = 8'd40;
    localparam logic [7:0] CrcLastBit  = 8'd46;

    state_e         state_q, state_d;
    logic [7:0]     bit_cnt_q, bit_cnt_d;
    logic [6:0]     ncr_q, ncr_d;
    logic [44:0]    rx_sr_q, rx_sr_d;    // token bits 2..46 once the end bit arrives
    logic [135:0]   tx_sr_q, tx_sr_d;    // response frame, MSB goes out first
    logic           resp_long_q, resp_long_d;
    logic           crc_ones_q, crc_ones_d;
    logic           cmd_o_q, cmd_o_d;
    logic           cmd_t_q, cmd_t_d;
    logic           valid_q, valid_d;
    logic [5:0]     index_q, index_d;
    logic [31:0]    arg_q, arg_d;
    logic           crc_err_q, crc_err_d;
    logic           end_err_q, end_err_d;

    logic           crc_clear, crc_en, crc_bit;
    logic [6:0]     crc;
    logic           ncr_expired;
    logic           rx_crc_bad;
    logic [7:0]     tx_idx;
    logic [7:0]     tx_last;
    logic           tx_bit;

    sd_crc7 u_crc7 (
        .clk_i   (sdclk_i),
        .rst_ni  (rst_cmd_ni),
        .clear_i (crc_clear),
        .en_i    (crc_en),
        .bit_i   (crc_bit),
        .crc_o   (crc)
    );

    // ncr_q is loaded with 1 at the end-bit edge E, so before edge E+k it reads
    // k (saturating); entering ST_TX on an edge with ncr_q == NcrCycles puts
    // the start bit on the line at E+1+NcrCycles at the earliest.
    assign ncr_expired = (ncr_q >= NcrMax);
    assign rx_crc_bad  = (rx_sr_q[6:0] != crc);
    assign tx_last     = resp_long_q ? LongLast : ShortLast;

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        ncr_d       = ncr_expired ? ncr_q : ncr_q + 7'd1;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        resp_long_d = resp_long_q;
        crc_ones_d  = crc_ones_q;
        cmd_o_d     = cmd_o_q;
        cmd_t_d     = cmd_t_q;
        valid_d     = 1'b0;
        index_d     = index_q;
        arg_d       = arg_q;
        crc_err_d   = crc_err_q;
        end_err_d   = end_err_q;
        crc_clear   = 1'b0;
        crc_en      = 1'b0;
        crc_bit     = 1'b0;
        tx_idx      = 8'd0;
        tx_bit      = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                rx_sr_d = {rx_sr_q[43:0], cmd_i};
                if (!cmd_i) begin
                    crc_clear = 1'b1;
                    crc_en    = 1'b1;
                    crc_bit   = cmd_i;
                    bit_cnt_d = 8'd1;
                    state_d   = ST_RX;
                end
            end

            ST_RX: begin
                rx_sr_d = {rx_sr_q[43:0], cmd_i};
                if (bit_cnt_q < CrcFirstBit) begin
                    crc_en  = 1'b1;
                    crc_bit = cmd_i;
                end
                if (bit_cnt_q == 8'd1 && !cmd_i) begin
                    // Transmission bit 0: a card-originated token, not ours.
                    state_d = ST_IDLE;
                end else if (bit_cnt_q == RxLastBit) begin
                    index_d   = rx_sr_q[44:39];
                    arg_d     = rx_sr_q[38:7];
                    crc_err_d = rx_crc_bad;
                    end_err_d = !cmd_i;
                    valid_d   = 1'b1;
                    ncr_d     = 7'd1;
                    state_d   = (rx_crc_bad || !cmd_i) ? ST_IDLE : ST_WAIT_RESP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 8'd1;
                end
            end

            ST_WAIT_RESP: begin
                if (resp_valid_i) begin
                    if (resp_none_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        resp_long_d = resp_long_i;
                        crc_ones_d  = resp_crc_ones_i;
                        // Short frames carry 7'h7F in the CRC slot; it is
                        // replaced by the computed CRC unless R3 is requested.
                        tx_sr_d     = resp_long_i
                            ? {2'b00, 6'h3F, resp_payload_i, 1'b1}
                            : {2'b00, resp_payload_i[37:0], CrcOnes, 1'b1, 88'd0};
                        state_d     = ncr_expired ? ST_TX : ST_NCR;
                    end
                end
            end

            ST_NCR: begin
                if (ncr_expired) begin
                    state_d = ST_TX;
                end
            end

            ST_TX: begin
                if (!cmd_t_q && bit_cnt_q == tx_last) begin
                    // End bit already on the line: release and re-arm.
                    cmd_t_d   = 1'b1;
                    cmd_o_d   = 1'b1;
                    bit_cnt_d = 8'd0;
                    state_d   = ST_IDLE;
                end else begin
                    // First TX edge still has the line released and drives
                    // bit 0; later edges advance the counter, so it tops out
                    // at the index of the last bit.
                    tx_idx = cmd_t_q ? 8'd0 : bit_cnt_q + 8'd1;
                    tx_bit = tx_sr_q[135];
                    if (!resp_long_q && !crc_ones_q &&
                        tx_idx >= CrcFirstBit && tx_idx <= CrcLastBit) begin
                        tx_bit = crc[6];
                    end
                    crc_clear = (tx_idx == 8'd0);
                    crc_en    = !resp_long_q && (tx_idx <= CrcLastBit);
                    crc_bit   = (tx_idx < CrcFirstBit) ? tx_sr_q[135] : crc[6];
                    tx_sr_d   = {tx_sr_q[134:0], 1'b0};
                    bit_cnt_d = tx_idx;
                    cmd_o_d   = tx_bit;
                    cmd_t_d   = 1'b0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sdclk_i or negedge rst_cmd_ni) begin
        if (!rst_cmd_ni) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 8'd0;
            ncr_q       <= 7'd0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            resp_long_q <= 1'b0;
            crc_ones_q  <= 1'b0;
            cmd_o_q     <= 1'b1;
            cmd_t_q     <= 1'b1;
            valid_q     <= 1'b0;
            index_q     <= 6'd0;
            arg_q       <= 32'd0;
            crc_err_q   <= 1'b0;
            end_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            ncr_q       <= ncr_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            resp_long_q <= resp_long_d;
            crc_ones_q  <= crc_ones_d;
            cmd_o_q     <= cmd_o_d;
            cmd_t_q     <= cmd_t_d;
            valid_q     <= valid_d;
            index_q     <= index_d;
            arg_q       <= arg_d;
            crc_err_q   <= crc_err_d;
            end_err_q   <= end_err_d;
        end
    end

    assign cmd_o               = cmd_o_q;
    assign cmd_t               = cmd_t_q;
    assign cmd_valid_o         = valid_q;
    assign cmd_index_o         = index_q;
    assign cmd_argument_o      = arg_q;
    assign cmd_crc_error_o     = crc_err_q;
    assign cmd_end_bit_error_o = end_err_q;
    assign resp_ready_o        = (state_q == ST_WAIT_RESP);

endmodule
